// File: rtl/ahb_arb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_arb_pkg
//   Shared AHB arbitration settings: default master count, HTRANS/HBURST
//   encodings and the burst-length helper used by the beat counter.
// ---------------------------------------------------------------------------
package ahb_arb_pkg;

    localparam int MASTER_COUNT = 3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    // Beats still to come after the NONSEQ beat of a burst. Undefined-length
    // bursts (SINGLE, INCR) return 0 so every beat is a rearbitration point.
    function automatic logic [3:0] burst_beats(input logic [2:0] burst);
        logic [3:0] beats;
        case (hburst_e'(burst))
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
            default:                      beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// ---------------------------------------------------------------------------
// ahb_rr_pick
//   Combinational round-robin picker. Searches the request vector starting
//   one position after the last owner, wrapping around, so the last owner is
//   checked last. With no request set, default_m wins.
//   Ports:
//     req    in   master_c        request vector
//     last   in   $clog2(master_c) index of the last owner
//     grant  out  master_c        one-hot winner (never zero)
// ---------------------------------------------------------------------------
module ahb_rr_pick
    import ahb_arb_pkg::*;
#(
    parameter int master_c  = MASTER_COUNT,
    parameter int default_m = 0,
    localparam int IW       = $clog2(master_c)
) (
    input  logic [master_c-1:0] req,
    input  logic [IW-1:0]       last,
    output logic [master_c-1:0] grant
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= master_c; i++) begin
            idx = IW'((int'(last) + i) % master_c);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        if (!found) begin
            grant[default_m] = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_arb.sv
// ---------------------------------------------------------------------------
// ahb_arb
//   Round-robin AHB bus arbiter. Holds the grant through fixed-length bursts
//   and while the granted master asserts hlock; otherwise rearbitrates on
//   every accepted beat. Publishes address-phase and data-phase owners.
//   Ports:
//     hclk, hresetn  clock, asynchronous active-low reset
//     hbusreq        per-master bus request
//     hlock          per-master lock request
//     htrans, hburst muxed transfer type / burst of the address-phase owner
//     hready         bus HREADY
//     hgrant         registered one-hot grant
//     hmaster        address-phase owner index
//     hmaster_d      data-phase owner index
//     hmastlock      current address-phase transfer is locked
//
//   Handshake: hready is the only transfer qualifier. A rising hclk edge with
//   hready=1 accepts the current beat and advances every register; with
//   hready=0 all state holds.
// ---------------------------------------------------------------------------
module ahb_arb
    import ahb_arb_pkg::*;
#(
    parameter int master_c  = MASTER_COUNT,
    parameter int default_m = 0,
    localparam int IW       = $clog2(master_c)
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic [master_c-1:0] hbusreq,
    input  logic [master_c-1:0] hlock,
    input  logic [1:0]          htrans,
    input  logic [2:0]          hburst,
    input  logic                hready,
    output logic [master_c-1:0] hgrant,
    output logic [IW-1:0]       hmaster,
    output logic [IW-1:0]       hmaster_d,
    output logic                hmastlock
);

    localparam logic [master_c-1:0] DEF_GRANT = master_c'(1) << default_m;
    localparam logic [IW-1:0]       DEF_IDX   = IW'(default_m);

    logic [3:0]          beats_left;
    logic [3:0]          beats_next;
    logic [IW-1:0]       gidx;
    logic [master_c-1:0] rr_pick;
    logic                rearb_ok;

    // Index of the current (pre-update) grant holder.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < master_c; i++) begin
            if (hgrant[i]) begin
                gidx = IW'(i);
            end
        end
    end

    // Beat counter next value; IDLE aborts a burst early, BUSY pauses it.
    always_comb begin
        beats_next = beats_left;
        case (htrans_e'(htrans))
            HTRANS_NONSEQ: beats_next = burst_beats(hburst);
            HTRANS_SEQ:    beats_next = (beats_left != 4'd0) ? beats_left - 4'd1 : 4'd0;
            HTRANS_IDLE:   beats_next = 4'd0;
            default:       beats_next = beats_left;
        endcase
    end

    // Rearbitrate only once the burst has no beats left and the owner is not
    // holding a lock.
    assign rearb_ok = (beats_next == 4'd0) && !hlock[gidx];

    ahb_rr_pick #(
        .master_c  (master_c),
        .default_m (default_m)
    ) u_rr_pick (
        .req   (hbusreq),
        .last  (gidx),
        .grant (rr_pick)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            beats_left <= 4'd0;
            hgrant     <= DEF_GRANT;
            hmaster    <= DEF_IDX;
            hmaster_d  <= DEF_IDX;
            hmastlock  <= 1'b0;
        end else if (hready) begin
            beats_left <= beats_next;
            if (rearb_ok) begin
                hgrant <= rr_pick;
            end
            hmaster   <= gidx;
            hmaster_d <= hmaster;
            hmastlock <= hlock[gidx];
        end
    end

endmodule

// File: tb/tb_ahb_arb.sv
// ---------------------------------------------------------------------------
// tb_ahb_arb
//   Directed bench for ahb_arb (master_c=3, default_m=0). The driver applies
//   one beat per cycle and pushes the hand-computed outputs it expects after
//   that edge; the monitor pops and compares on each falling edge.
//   Expected word layout: {hgrant[2:0], hmaster[1:0], hmaster_d[1:0], hmastlock}.
// ---------------------------------------------------------------------------
module tb_ahb_arb;
    import ahb_arb_pkg::*;

    localparam int W = 8;

    logic       hclk;
    logic       hresetn;
    logic [2:0] hbusreq;
    logic [2:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [2:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_d;
    logic       hmastlock;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           failures;

    ahb_arb #(
        .master_c  (3),
        .default_m (0)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmaster_d (hmaster_d),
        .hmastlock (hmastlock)
    );

    // ---------------- clock / reset ----------------
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge hclk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        string        nm;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {hgrant, hmaster, hmaster_d, hmastlock};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s: got grant=%b m=%0d md=%0d lk=%b, expected grant=%b m=%0d md=%0d lk=%b",
                         nm, got[7:5], got[4:3], got[2:1], got[0],
                         exp[7:5], exp[4:3], exp[2:1], exp[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [W-1:0] pack(input logic [2:0] g, input int m,
                                          input int md, input logic lk);
        return {g, 2'(m), 2'(md), lk};
    endfunction

    task automatic expect_out(input logic [W-1:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Called right after a falling edge: drive one beat, let the rising edge
    // happen, then queue what the outputs must show at the next falling edge.
    task automatic step(input logic [2:0] req, input logic [2:0] lk,
                        input htrans_e tr, input hburst_e bu, input logic rdy,
                        input logic [W-1:0] exp, input string nm);
        hbusreq = req;
        hlock   = lk;
        htrans  = tr;
        hburst  = bu;
        hready  = rdy;
        @(posedge hclk);
        #1;
        expect_out(exp, nm);
        @(negedge hclk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wait_cnt;
        checks   = 0;
        failures = 0;
        hresetn  = 1'b0;
        hbusreq  = '0;
        hlock    = '0;
        htrans   = HTRANS_IDLE;
        hburst   = HBURST_SINGLE;
        hready   = 1'b1;

        // 1. reset and idle
        repeat (2) @(negedge hclk);
        #1;
        expect_out(pack(3'b001, 0, 0, 1'b0), "reset");
        @(negedge hclk);
        hresetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(3'b000, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1,
                 pack(3'b001, 0, 0, 1'b0), "idle_hold");
        end

        // 2. round-robin on SINGLE beats
        step(3'b111, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, pack(3'b010, 0, 0, 1'b0), "rr_1");
        step(3'b111, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, pack(3'b100, 1, 0, 1'b0), "rr_2");
        step(3'b111, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, pack(3'b001, 2, 1, 1'b0), "rr_3");
        step(3'b111, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, pack(3'b010, 0, 2, 1'b0), "rr_4");

        // 3. INCR4 by master 1; its request drops mid-burst, master 2 waits
        step(3'b110, 3'b000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, pack(3'b010, 1, 0, 1'b0), "incr4_nseq");
        step(3'b100, 3'b000, HTRANS_SEQ,    HBURST_INCR4, 1'b1, pack(3'b010, 1, 1, 1'b0), "incr4_seq1");
        step(3'b100, 3'b000, HTRANS_SEQ,    HBURST_INCR4, 1'b1, pack(3'b010, 1, 1, 1'b0), "incr4_seq2");
        step(3'b100, 3'b000, HTRANS_SEQ,    HBURST_INCR4, 1'b1, pack(3'b100, 1, 1, 1'b0), "incr4_seq3");
        step(3'b100, 3'b000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, pack(3'b100, 2, 1, 1'b0), "incr4_handover");

        // 4. INCR8 by master 2 with a 3-cycle stall, then early IDLE
        step(3'b101, 3'b000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1, pack(3'b100, 2, 2, 1'b0), "incr8_nseq");
        step(3'b101, 3'b000, HTRANS_SEQ,    HBURST_INCR8, 1'b1, pack(3'b100, 2, 2, 1'b0), "incr8_seq1");
        for (int i = 0; i < 3; i++) begin
            step(3'b101, 3'b000, HTRANS_IDLE, HBURST_INCR8, 1'b0, pack(3'b100, 2, 2, 1'b0), "stall_hold");
        end
        step(3'b101, 3'b000, HTRANS_SEQ,    HBURST_INCR8, 1'b1, pack(3'b100, 2, 2, 1'b0), "incr8_seq2");
        step(3'b101, 3'b000, HTRANS_SEQ,    HBURST_INCR8, 1'b1, pack(3'b100, 2, 2, 1'b0), "incr8_seq3");
        step(3'b101, 3'b000, HTRANS_IDLE,   HBURST_INCR8, 1'b1, pack(3'b001, 2, 2, 1'b0), "early_idle");

        // 5. lock by master 2
        step(3'b100, 3'b000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, pack(3'b100, 0, 2, 1'b0), "to_m2");
        step(3'b111, 3'b100, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, pack(3'b100, 2, 0, 1'b1), "lock_1");
        for (int i = 0; i < 4; i++) begin
            step(3'b111, 3'b100, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, pack(3'b100, 2, 2, 1'b1), "lock_hold");
        end
        step(3'b111, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, pack(3'b001, 2, 2, 1'b0), "unlock");
        step(3'b111, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, pack(3'b010, 0, 2, 1'b0), "after_unlock");

        // 6. async reset during INCR16 by master 1
        step(3'b010, 3'b000, HTRANS_NONSEQ, HBURST_INCR16, 1'b1, pack(3'b010, 1, 0, 1'b0), "incr16_nseq");
        step(3'b010, 3'b000, HTRANS_SEQ,    HBURST_INCR16, 1'b1, pack(3'b010, 1, 1, 1'b0), "incr16_seq1");
        htrans = HTRANS_SEQ;
        @(posedge hclk);
        #2;
        hresetn = 1'b0;
        #1;
        expect_out(pack(3'b001, 0, 0, 1'b0), "async_reset");
        @(negedge hclk);
        hresetn = 1'b1;
        step(3'b100, 3'b000, HTRANS_SEQ,  HBURST_INCR16, 1'b1, pack(3'b100, 0, 0, 1'b0), "no_resume");
        step(3'b000, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, pack(3'b001, 2, 0, 1'b0), "back_default");

        // drain the scoreboard, bounded
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge hclk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
